spi_slave_responder: RTL and testbench

- SPI mode-0 slave: the device-side counterpart of the team's SD-card SPI master, used as a synthesizable card/peripheral responder in FPGA loopback and bring-up builds.
- Oversamples SCK, MOSI and CS on the local system clock.
- Deframes received bytes to local logic and serializes local reply bytes onto MISO.
- Drives MISO high whenever it has no data to send, following the SD idle-0xFF convention.

---
 rtl/spi_slave_responder.sv | 205 ++++++++++++++++++++
 tb/tb_spi_slave_responder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_responder.sv
// SPI mode-0 slave responder: oversamples SCK/MOSI/CS on CLK, deframes received bytes and
// serializes reply bytes onto MISO, idling MISO high when nothing is queued.
module spi_slave_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  IDLE_BYTE   = 8'hFF,
    parameter int unsigned CNT_W       = 10
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             SCK,
    input  logic             MOSI,
    input  logic             CS,
    output logic             MISO,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    input  logic [7:0]       tx_data,
    input  logic             tx_load,
    output logic             tx_ready,
    output logic             tx_underrun,
    output logic             frame_start,
    output logic             frame_end,
    output logic [CNT_W-1:0] byte_cnt
);

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] fill_q, fill_d;
    logic                   sck_prev_q, sck_prev_d;
    logic                   cs_prev_q, cs_prev_d;
    logic                   armed_q, armed_d;

    state_e                 state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [6:0]             rxsh_q, rxsh_d;
    logic [7:0]             txsh_q, txsh_d;
    logic [7:0]             hold_q, hold_d;
    logic                   hold_full_q, hold_full_d;
    logic                   skip_reload_q, skip_reload_d;

    logic                   miso_q, miso_d;
    logic [7:0]             rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   tx_underrun_q, tx_underrun_d;
    logic                   frame_start_q, frame_start_d;
    logic                   frame_end_q, frame_end_d;
    logic [CNT_W-1:0]       byte_cnt_q, byte_cnt_d;

    logic sck_s, mosi_s, cs_s;
    logic sck_rise, sck_fall, cs_fall, cs_rise;
    logic reload;

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign cs_fall  = ~cs_s & cs_prev_q;
    assign cs_rise  = cs_s & ~cs_prev_q;

    always_comb begin
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], SCK};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], CS};
        fill_d      = {fill_q[SYNC_STAGES-2:0], 1'b1};
        sck_prev_d  = sck_s;
        cs_prev_d   = cs_s;
        // Only a CS that has been genuinely sampled high arms frame detection, so a CS held
        // low across reset release does not look like a falling edge of the preset value.
        armed_d     = armed_q | (fill_q[SYNC_STAGES-1] & cs_s);

        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        rxsh_d        = rxsh_q;
        txsh_d        = txsh_q;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        skip_reload_d = skip_reload_q;
        rx_data_d     = rx_data_q;
        byte_cnt_d    = byte_cnt_q;
        rx_valid_d    = 1'b0;
        tx_underrun_d = 1'b0;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        reload        = 1'b0;

        case (state_q)
            StIdle: begin
                if (cs_fall && armed_q) begin
                    state_d       = StActive;
                    frame_start_d = 1'b1;
                    bit_cnt_d     = 3'd0;
                    byte_cnt_d    = '0;
                    skip_reload_d = 1'b1;
                    reload        = 1'b1;
                end
            end
            StActive: begin
                if (cs_rise) begin
                    state_d     = StIdle;
                    frame_end_d = 1'b1;
                    bit_cnt_d   = 3'd0;
                    txsh_d      = 8'hFF;
                end else if (sck_rise) begin
                    rxsh_d        = {rxsh_q[5:0], mosi_s};
                    bit_cnt_d     = bit_cnt_q + 3'd1;
                    skip_reload_d = 1'b0;
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_d  = {rxsh_q, mosi_s};
                        rx_valid_d = 1'b1;
                        if (byte_cnt_q != {CNT_W{1'b1}}) begin
                            byte_cnt_d = byte_cnt_q + 1'b1;
                        end
                    end
                end else if (sck_fall) begin
                    // A falling edge before the first rising edge follows the frame-start load.
                    if (bit_cnt_q == 3'd0) begin
                        reload = ~skip_reload_q;
                    end else begin
                        txsh_d = {txsh_q[6:0], 1'b1};
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (reload) begin
            if (hold_full_q) begin
                txsh_d      = hold_q;
                hold_full_d = 1'b0;
            end else begin
                txsh_d        = IDLE_BYTE;
                tx_underrun_d = 1'b1;
            end
        end

        // A load races a boundary reload by landing after it: the reload saw an empty register.
        if (tx_load && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end

        miso_d = (state_d == StActive) ? txsh_d[7] : 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sck_sync_q    <= '0;
            mosi_sync_q   <= '1;
            cs_sync_q     <= '1;
            fill_q        <= '0;
            sck_prev_q    <= 1'b0;
            cs_prev_q     <= 1'b1;
            armed_q       <= 1'b0;
            state_q       <= StIdle;
            bit_cnt_q     <= 3'd0;
            rxsh_q        <= 7'h7F;
            txsh_q        <= 8'hFF;
            hold_q        <= 8'h00;
            hold_full_q   <= 1'b0;
            skip_reload_q <= 1'b0;
            miso_q        <= 1'b1;
            rx_data_q     <= 8'h00;
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            byte_cnt_q    <= '0;
        end else begin
            sck_sync_q    <= sck_sync_d;
            mosi_sync_q   <= mosi_sync_d;
            cs_sync_q     <= cs_sync_d;
            fill_q        <= fill_d;
            sck_prev_q    <= sck_prev_d;
            cs_prev_q     <= cs_prev_d;
            armed_q       <= armed_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            rxsh_q        <= rxsh_d;
            txsh_q        <= txsh_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            skip_reload_q <= skip_reload_d;
            miso_q        <= miso_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            tx_underrun_q <= tx_underrun_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            byte_cnt_q    <= byte_cnt_d;
        end
    end

    assign MISO        = miso_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_ready    = ~hold_full_q;
    assign tx_underrun = tx_underrun_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;
    assign byte_cnt    = byte_cnt_q;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench for spi_slave_responder: a mode-0 master plus a transaction-level model of
// the holding register, reply bytes, pulse counts and received bytes.
module tb_spi_slave_responder;

    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sck = 1'b0;
    logic       mosi = 1'b1;
    logic       cs = 1'b1;
    logic       miso;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data = 8'h00;
    logic       tx_load = 1'b0;
    logic       tx_ready;
    logic       tx_underrun;
    logic       frame_start;
    logic       frame_end;
    logic [9:0] byte_cnt;

    spi_slave_responder dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .SCK        (sck),
        .MOSI       (mosi),
        .CS         (cs),
        .MISO       (miso),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_load    (tx_load),
        .tx_ready   (tx_ready),
        .tx_underrun(tx_underrun),
        .frame_start(frame_start),
        .frame_end  (frame_end),
        .byte_cnt   (byte_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: single-entry holding register, next reply byte, expected pulse counts.
    bit         m_full = 1'b0;
    logic [7:0] m_val = 8'h00;
    logic [7:0] m_next = 8'hFF;
    bit         m_active = 1'b0;
    int         m_cnt = 0;
    int         exp_fs = 0, exp_fe = 0, exp_und = 0;
    int         cnt_fs = 0, cnt_fe = 0, cnt_und = 0;
    logic [17:0] exp_rx[$];
    logic [17:0] e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] m_pop();
        if (m_full) begin
            m_full = 1'b0;
            return m_val;
        end
        exp_und++;
        return 8'hFF;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_start) cnt_fs++;
            if (frame_end) cnt_fe++;
            if (tx_underrun) cnt_und++;
            if (rx_valid) begin
                check("rx_pending", 32'(exp_rx.size() != 0), 32'd1);
                if (exp_rx.size() != 0) begin
                    e = exp_rx.pop_front();
                    check("rx_data", 32'(rx_data), 32'(e[7:0]));
                    check("byte_cnt_on_rx", 32'(byte_cnt), 32'(e[17:8]));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] v);
        check("tx_ready_before_load", 32'(tx_ready), 32'(!m_full));
        tx_data = v;
        tx_load = 1'b1;
        tick(1);
        tx_load = 1'b0;
        if (!m_full) begin
            m_full = 1'b1;
            m_val  = v;
        end
        check("tx_ready_after_load", 32'(tx_ready), 32'(!m_full));
        tick(2);
    endtask

    task automatic cs_low();
        m_next   = m_pop();
        exp_fs++;
        m_active = 1'b1;
        m_cnt    = 0;
        cs       = 1'b0;
        tick(HALF);
    endtask

    task automatic cs_high();
        cs = 1'b1;
        tick(HALF);
        if (m_active) exp_fe++;
        m_active = 1'b0;
        check("miso_idle", 32'(miso), 32'd1);
        check("frame_start_count", 32'(cnt_fs), 32'(exp_fs));
        check("frame_end_count", 32'(cnt_fe), 32'(exp_fe));
        check("underrun_count", 32'(cnt_und), 32'(exp_und));
        check("rx_all_seen", 32'(exp_rx.size()), 32'd0);
        check("byte_cnt_hold", 32'(byte_cnt), 32'(m_cnt));
    endtask

    // Mode 0: MOSI set during SCK low, MISO sampled just before the rising edge.
    task automatic xfer_byte(input logic [7:0] m, input int nbits, output logic [7:0] got);
        got = 8'hFF;
        for (int i = 0; i < nbits; i++) begin
            mosi = m[7-i];
            tick(HALF);
            got[7-i] = miso;
            if (nbits == 8 && i == 7) begin
                m_cnt++;
                exp_rx.push_back({10'(m_cnt), m});
            end
            sck = 1'b1;
            tick(HALF);
            sck = 1'b0;
            tick(1);
        end
        tick(HALF);
        if (nbits == 8) begin
            check("miso_byte", 32'(got), 32'(m_next));
            m_next = m_pop();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] g1, g2, g3;
        tick(3);
        check("reset_miso", 32'(miso), 32'd1);
        check("reset_rx_data", 32'(rx_data), 32'h00);
        check("reset_byte_cnt", 32'(byte_cnt), 32'd0);
        check("reset_tx_ready", 32'(tx_ready), 32'd1);
        rst_n = 1'b1;
        tick(4);

        // CS high: SCK activity is ignored.
        for (int i = 0; i < 8; i++) begin
            sck = ~sck;
            tick(HALF);
            check("idle_miso", 32'(miso), 32'd1);
        end
        check("idle_no_frame_start", 32'(cnt_fs), 32'd0);
        check("idle_no_underrun", 32'(cnt_und), 32'd0);

        // Preloaded reply, one-byte frame.
        load(8'hA5);
        cs_low();
        xfer_byte(8'h3C, 8, g1);
        cs_high();
        check("t2_miso_lit", 32'(g1), 32'hA5);
        check("t2_rx_lit", 32'(rx_data), 32'h3C);
        check("t2_cnt_lit", 32'(byte_cnt), 32'd1);

        // Three bytes, reply loaded after frame start only.
        cs_low();
        load(8'h01);
        xfer_byte(8'h40, 8, g1);
        xfer_byte(8'h00, 8, g2);
        xfer_byte(8'h95, 8, g3);
        cs_high();
        check("t3_b1_lit", 32'(g1), 32'hFF);
        check("t3_b2_lit", 32'(g2), 32'h01);
        check("t3_b3_lit", 32'(g3), 32'hFF);
        check("t3_cnt_lit", 32'(byte_cnt), 32'd3);
        check("t3_rx_lit", 32'(rx_data), 32'h95);

        // Load while full is dropped.
        load(8'h11);
        load(8'h22);
        cs_low();
        xfer_byte(8'hC3, 8, g1);
        cs_high();
        check("t4_miso_lit", 32'(g1), 32'h11);

        // Aborted partial byte, then a clean frame realigns.
        cs_low();
        xfer_byte(8'hFE, 5, g1);
        cs_high();
        cs_low();
        xfer_byte(8'h12, 8, g1);
        cs_high();
        check("t5_rx_lit", 32'(rx_data), 32'h12);
        check("t5_miso_lit", 32'(g1), 32'hFF);

        // Reset mid-byte with CS held low.
        load(8'h77);
        cs_low();
        xfer_byte(8'hA0, 4, g1);
        rst_n = 1'b0;
        #1;
        check("rst_miso", 32'(miso), 32'd1);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_byte_cnt", 32'(byte_cnt), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_pulses", 32'({rx_valid, frame_start, frame_end, tx_underrun}), 32'd0);
        m_full   = 1'b0;
        m_active = 1'b0;
        m_cnt    = 0;
        tick(3);
        rst_n = 1'b1;
        tick(4);
        for (int i = 0; i < 8; i++) begin
            mosi = i[0];
            tick(HALF);
            check("post_rst_miso", 32'(miso), 32'd1);
            sck = 1'b1;
            tick(HALF);
            sck = 1'b0;
        end
        tick(HALF);
        check("post_rst_no_start", 32'(cnt_fs), 32'(exp_fs));
        cs_high();
        cs_low();
        xfer_byte(8'h5A, 8, g1);
        cs_high();
        check("t6_rx_lit", 32'(rx_data), 32'h5A);
        check("t6_miso_lit", 32'(g1), 32'hFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
